// File: rtl/calc_pkg.sv
// Shared encodings for the calculator display path.
// Status codes and active-low seven-segment glyphs {g,f,e,d,c,b,a}.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_ERR   = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10,
    ST_IDLE  = 2'b11
  } status_e;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_EH = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_r     = 7'h2F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  function automatic logic [6:0] hex_glyph(
    input logic [3:0] v
  );
    logic [6:0] g;
    unique case (v)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_EH;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/calc_display_scan_seg7.sv
// Hex digit to active-low seven-segment pattern.
// A set blank flag turns every segment off.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  // pure lookup, blank wins over the value
  always_comb begin
    seg = hex_glyph(value);
    if (blank) seg = GLYPH_BLANK;
  end

endmodule

// File: rtl/calc_display_scan.sv
// Digit register file, scan timing and output registers
// for the 8-digit multiplexed display and status LEDs.
module calc_display_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       led_err,
  output logic       led_busy,
  output logic       led_ready
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PTC = PW'(SCAN_DIV - 1);

  logic [3:0]    digit_reg [8];
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          upper_nz;
  logic          lz_blank;
  logic [6:0]    dec_seg;
  logic [6:0]    glyph;
  logic [7:0]    seg_nxt;

  // register file, slots 8..15 are dropped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++)
        digit_reg[i] <= '0;
    end else if (!pos[3]) begin
      digit_reg[pos[2:0]] <= data;
    end
  end

  // prescaler and scan index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PTC) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // leading-zero test over the current slot and all above it
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < 8; i++)
      if (3'(i) >= idx && digit_reg[i] != 4'd0)
        upper_nz = 1'b1;
    lz_blank = BLANK_LZ && idx != 3'd0 && !upper_nz;
  end

  seg7_decoder u_dec (
    .value (digit_reg[idx]),
    .blank (lz_blank),
    .seg   (dec_seg)
  );

  // error override, then the busy dot on slot 0
  always_comb begin
    priority case (1'b1)
      status != ST_ERR: glyph = dec_seg;
      idx == 3'd2:      glyph = GLYPH_E;
      idx < 3'd2:       glyph = GLYPH_r;
      default:          glyph = GLYPH_BLANK;
    endcase
    seg_nxt = {~(status == ST_BUSY && idx == 3'd0), glyph};
  end

  // an/seg reload together every cycle; LEDs follow status
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an        <= 8'hFF;
      seg       <= 8'hFF;
      led_err   <= 1'b0;
      led_busy  <= 1'b0;
      led_ready <= 1'b0;
    end else begin
      an        <= ~(8'b1 << idx);
      seg       <= seg_nxt;
      led_err   <= status == ST_ERR;
      led_busy  <= status == ST_BUSY;
      led_ready <= status == ST_READY;
    end
  end

endmodule

// File: tb/tb_calc_display_scan.sv
// Random and directed checks of calc_display_scan against
// a cycle-count based model, with and without zero blanking.
module tb_calc_display_scan;

  localparam int SD = 4;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] status = 2'b11;
  logic [3:0] data = '0;
  logic [3:0] pos = 4'hF;

  logic [7:0] an0, seg0, an1, seg1;
  logic       le0, lb0, lr0, le1, lb1, lr1;

  int total = 0;
  int bad = 0;
  int n = 0;
  logic [31:0] val = '0;

  always #5 clock = ~clock;

  calc_display_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut0 (
    .clock(clock), .reset(reset), .status(status),
    .data(data), .pos(pos), .an(an0), .seg(seg0),
    .led_err(le0), .led_busy(lb0), .led_ready(lr0)
  );

  calc_display_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut1 (
    .clock(clock), .reset(reset), .status(status),
    .data(data), .pos(pos), .an(an1), .seg(seg1),
    .led_err(le1), .led_busy(lb1), .led_ready(lr1)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input bit blz, input int ix,
                                       input logic [1:0] s,
                                       input logic [31:0] v);
    logic [31:0] up;
    logic [7:0] g;
    up = v >> (4 * ix);
    if (s == 2'b00)
      g = (ix == 2) ? 8'h86 : (ix < 2) ? 8'hAF : 8'hFF;
    else if (blz && ix != 0 && up == 0)
      g = 8'hFF;
    else
      g = HEX[up[3:0]];
    if (s == 2'b01 && ix == 0) g[7] = 1'b0;
    return g;
  endfunction

  task automatic step(input logic [3:0] p, input logic [3:0] d,
                      input logic [1:0] s);
    int ix;
    logic [7:0] e_an, e_s0, e_s1, e_led;
    pos = p;
    data = d;
    status = s;
    @(posedge clock);
    ix = (n / SD) % 8;
    e_an = ~(8'd1 << ix);
    e_s0 = glyph(1'b1, ix, s, val);
    e_s1 = glyph(1'b0, ix, s, val);
    e_led = {5'd0, s == 2'b00, s == 2'b01, s == 2'b10};
    n++;
    if (p < 8) val[int'(p) * 4 +: 4] = d;
    @(negedge clock);
    chk("an_lz", an0, e_an);
    chk("an_all", an1, e_an);
    chk("seg_lz", seg0, e_s0);
    chk("seg_all", seg1, e_s1);
    chk("led_lz", {5'd0, le0, lb0, lr0}, e_led);
    chk("led_all", {5'd0, le1, lb1, lr1}, e_led);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int i = 0; i <= cycles; i++) begin
      chk("rst_an", an0, 8'hFF);
      chk("rst_seg", seg0, 8'hFF);
      chk("rst_an1", an1, 8'hFF);
      chk("rst_seg1", seg1, 8'hFF);
      chk("rst_led", {5'd0, le0, lb0, lr0}, 8'h00);
      if (i < cycles) @(negedge clock);
    end
    n = 0;
    val = '0;
    reset = 1'b1;
  endtask

  initial begin
    do_reset(3);
    step(4'd0, 4'd5, 2'b11);
    step(4'd1, 4'd2, 2'b11);
    repeat (40) step(4'hF, 4'd0, 2'b11);

    for (int i = 0; i < 8; i++) step(4'(i), 4'd0, 2'b11);
    repeat (36) step(4'hF, 4'd0, 2'b11);

    step(4'd0, 4'd3, 2'b11);
    step(4'd1, 4'd2, 2'b11);
    step(4'd2, 4'd1, 2'b11);
    repeat (32) step(4'hF, 4'd0, 2'b11);
    repeat (33) step(4'hF, 4'd0, 2'b00);
    repeat (33) step(4'hF, 4'd0, 2'b10);

    repeat (10) step(4'd9, 4'd7, 2'b10);
    repeat (33) step(4'hF, 4'd0, 2'b01);

    repeat (6) step(4'hF, 4'd0, 2'b10);
    do_reset(2);
    repeat (10) step(4'hF, 4'd0, 2'b11);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(2);
      if ($urandom_range(0, 15) == 0)
        status = 2'($urandom_range(0, 3));
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           status);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
